// File: rtl/dmem_responder_128x32.sv
// Synthesizable data-memory responder for the single-cycle MIPS data port.
// Active-low SRAM-style request side, registered read data, optional power-on clear.
module dmem_responder_128x32 #(
    parameter int unsigned DW             = 32,
    parameter int unsigned AW             = 7,
    parameter int unsigned DEPTH          = 128,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CEN,
    input  logic          WEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    input  logic          OEN,
    output logic [DW-1:0] Q,
    output logic          busy,
    output logic          addr_err
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Pointer is one bit wider than the address so DEPTH == 2**AW ends cleanly.
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);

    logic [DW-1:0] mem [0:DEPTH-1];

    state_t        state_q, state_d;
    logic [AW:0]   clrPtr_q, clrPtr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          addrErr_q, addrErr_d;

    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic          inRange;

    assign inRange = ({1'b0, A} < DEPTH_C);

    always_comb begin
        state_d   = state_q;
        clrPtr_d  = clrPtr_q;
        rdata_d   = rdata_q;
        addrErr_d = 1'b0;
        memWe     = 1'b0;
        memAddr   = A;
        memWdata  = D;

        case (state_q)
            CLEAR: begin
                memWe    = 1'b1;
                memAddr  = clrPtr_q[AW-1:0];
                memWdata = '0;
                clrPtr_d = clrPtr_q + 1'b1;
                if (clrPtr_q == LAST_C) begin
                    state_d  = READY;
                    clrPtr_d = '0;
                end
            end
            READY: begin
                if (!CEN) begin
                    if (!inRange) begin
                        // Out-of-range writes vanish; out-of-range reads return zero.
                        addrErr_d = 1'b1;
                        if (WEN) begin
                            rdata_d = '0;
                        end
                    end else if (!WEN) begin
                        memWe = 1'b1;
                    end else begin
                        rdata_d = mem[A];
                    end
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
            clrPtr_q  <= '0;
            rdata_q   <= '0;
            addrErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clrPtr_q  <= clrPtr_d;
            rdata_q   <= rdata_d;
            addrErr_q <= addrErr_d;
        end
    end

    // Storage has no reset so it maps onto block RAM; reset only suppresses the write.
    always_ff @(posedge clk) begin
        if (memWe && !rst) begin
            mem[memAddr] <= memWdata;
        end
    end

    assign Q        = OEN ? '0 : rdata_q;
    assign busy     = (state_q == CLEAR);
    assign addr_err = addrErr_q;

endmodule

// File: tb/tb_dmem_responder_128x32.sv
// Self-checking bench: a cleared 128-word instance and a 100-word non-clearing
// instance, driven by directed steps plus random traffic against an array model.
module tb_dmem_responder_128x32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, cen0, wen0, oen0;
    logic [6:0]  a0;
    logic [31:0] d0, q0;
    logic        busy0, err0;

    logic        rst1, cen1, wen1, oen1;
    logic [6:0]  a1;
    logic [31:0] d1, q1;
    logic        busy1, err1;

    dmem_responder_128x32 #(.DW(32), .AW(7), .DEPTH(128), .CLEAR_ON_RESET(1'b1)) dut0 (
        .clk(clk), .rst(rst0), .CEN(cen0), .WEN(wen0), .A(a0), .D(d0),
        .OEN(oen0), .Q(q0), .busy(busy0), .addr_err(err0)
    );

    dmem_responder_128x32 #(.DW(32), .AW(7), .DEPTH(100), .CLEAR_ON_RESET(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .CEN(cen1), .WEN(wen1), .A(a1), .D(d1),
        .OEN(oen1), .Q(q1), .busy(busy1), .addr_err(err1)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: word arrays, the last read value, and readiness per instance
    logic [31:0] m0 [0:127];
    logic [31:0] m1 [0:127];
    logic [31:0] qm0, qm1;
    bit          ready0, ready1;

    int busySeen1 = 0;
    always @(negedge clk) if (busy1 === 1'b1) busySeen1++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the chosen instance, one edge, then check Q and addr_err.
    task automatic applyStimulus(input int sel, input logic wen, input logic [6:0] a,
                                 input logic [31:0] d, input string tag);
        logic expErr;
        int   depth;
        bit   inReset, rdy;
        expErr = 1'b0;
        depth  = (sel == 0) ? 128 : 100;
        if (sel == 0) begin
            cen0 = 1'b0; wen0 = wen; a0 = a; d0 = d;
        end else begin
            cen1 = 1'b0; wen1 = wen; a1 = a; d1 = d;
        end
        @(posedge clk);
        inReset = (sel == 0) ? (rst0 === 1'b1) : (rst1 === 1'b1);
        rdy     = (sel == 0) ? ready0 : ready1;
        if (inReset) begin
            if (sel == 0) qm0 = '0; else qm1 = '0;
        end else if (rdy) begin
            if (int'(a) >= depth) begin
                expErr = 1'b1;
                if (wen) begin
                    if (sel == 0) qm0 = '0; else qm1 = '0;
                end
            end else if (!wen) begin
                if (sel == 0) m0[a] = d; else m1[a] = d;
            end else begin
                if (sel == 0) qm0 = m0[a]; else qm1 = m1[a];
            end
        end
        #1;
        if (sel == 0) begin
            cen0 = 1'b1;
            checkOutput({tag, "_q"}, q0, oen0 ? 32'd0 : qm0);
            checkOutput({tag, "_err"}, {31'd0, err0}, {31'd0, expErr});
        end else begin
            cen1 = 1'b1;
            checkOutput({tag, "_q"}, q1, oen1 ? 32'd0 : qm1);
            checkOutput({tag, "_err"}, {31'd0, err1}, {31'd0, expErr});
        end
    endtask

    task automatic idleCycle(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_err0"}, {31'd0, err0}, 32'd0);
        checkOutput({tag, "_err1"}, {31'd0, err1}, 32'd0);
        checkOutput({tag, "_q0"}, q0, oen0 ? 32'd0 : qm0);
        checkOutput({tag, "_q1"}, q1, oen1 ? 32'd0 : qm1);
    endtask

    // Counts edges with busy high after reset release; the clear must take 128 edges.
    task automatic waitClear(input string tag);
        int cnt;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput({tag, "_len"}, cnt, 32'd128);
        checkOutput({tag, "_q"}, q0, 32'd0);
        for (int i = 0; i < 128; i++) m0[i] = '0;
        ready0 = 1'b1;
    endtask

    initial begin
        cen0 = 1'b1; wen0 = 1'b1; oen0 = 1'b0; a0 = '0; d0 = '0;
        cen1 = 1'b1; wen1 = 1'b1; oen1 = 1'b0; a1 = '0; d1 = '0;
        rst0 = 1'b1; rst1 = 1'b1;
        qm0 = '0; qm1 = '0; ready0 = 1'b0; ready1 = 1'b1;
        for (int i = 0; i < 128; i++) begin
            m0[i] = 'x;
            m1[i] = 'x;
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_q0", q0, 32'd0);
        checkOutput("rst_q1", q1, 32'd0);
        checkOutput("rst_busy0", {31'd0, busy0}, 32'd1);
        checkOutput("rst_busy1", {31'd0, busy1}, 32'd0);
        checkOutput("rst_err0", {31'd0, err0}, 32'd0);
        checkOutput("rst_err1", {31'd0, err1}, 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        waitClear("clear1");
        applyStimulus(0, 1'b1, 7'd0,   32'd0, "clr_rd0");
        applyStimulus(0, 1'b1, 7'd64,  32'd0, "clr_rd64");
        applyStimulus(0, 1'b1, 7'd127, 32'd0, "clr_rd127");

        applyStimulus(1, 1'b0, 7'd0, 32'd15, "wr0");
        applyStimulus(1, 1'b0, 7'd1, 32'd20, "wr1");
        applyStimulus(1, 1'b1, 7'd0, 32'd0,  "rd0");
        applyStimulus(1, 1'b1, 7'd1, 32'd0,  "rd1");
        applyStimulus(1, 1'b0, 7'd4, 32'd30, "wr4_hold");
        applyStimulus(1, 1'b1, 7'd4, 32'd0,  "raw4");

        oen1 = 1'b1;
        applyStimulus(1, 1'b1, 7'd1, 32'd0, "oen_rd1");
        oen1 = 1'b0;
        #1;
        checkOutput("oen_release", q1, 32'd20);

        applyStimulus(1, 1'b0, 7'd100, 32'hDEADBEEF, "oor_wr");
        idleCycle("oor_pulse");
        applyStimulus(1, 1'b0, 7'd99,  32'hCAFE0099, "wr99");
        applyStimulus(1, 1'b1, 7'd100, 32'd0, "oor_rd");
        applyStimulus(1, 1'b1, 7'd99,  32'd0, "rd99");
        applyStimulus(1, 1'b1, 7'd127, 32'd0, "oor_rd127");

        applyStimulus(1, 1'b0, 7'd2, 32'hAAAA0002, "wr2");
        applyStimulus(1, 1'b1, 7'd2, 32'd0, "rd2");
        rst1 = 1'b1;
        applyStimulus(1, 1'b0, 7'd2, 32'h11112222, "rst_wr2");
        rst1 = 1'b0;
        applyStimulus(1, 1'b1, 7'd2, 32'd0, "rd2_after_rst");

        for (int i = 0; i < 100; i++)
            applyStimulus(1, 1'b0, 7'(i), $urandom, "fill1");
        for (int i = 0; i < 300; i++) begin
            oen1 = 1'($urandom_range(0, 1));
            applyStimulus(1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom, "rand1");
        end
        oen1 = 1'b0;
        for (int i = 0; i < 200; i++)
            applyStimulus(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom, "rand0");

        applyStimulus(0, 1'b0, 7'd5, 32'h00005555, "pre_wr5");
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        qm0 = '0;
        ready0 = 1'b0;
        rst0 = 1'b0;
        applyStimulus(0, 1'b0, 7'd5, 32'h5A5A5A5A, "clr_wr5");
        repeat (48) @(posedge clk);
        #1;
        checkOutput("clr_mid_busy", {31'd0, busy0}, 32'd1);
        rst0 = 1'b1;
        idleCycle("clr_restart");
        rst0 = 1'b0;
        waitClear("clear2");
        applyStimulus(0, 1'b1, 7'd5, 32'd0, "rd5_after_clr");

        checkOutput("busy1_never", busySeen1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dmem_responder_128x32.md
# dmem_responder_128x32

Synthesizable data-memory responder for the single-cycle MIPS data port. It answers the core's active-low SRAM-style requests (CEN/WEN/OEN, 7-bit word address, 32-bit write data) with a registered read path. It also provides an optional power-on clear sequencer and out-of-range detection. It replaces the behavioural HSs18n_128x32 macro in gate-level and FPGA builds; the core side of the interface is unchanged.

## Interface
- DW, 32, data width in bits
- AW, 7, word-address width
- DEPTH, 128, implemented words; must satisfy DEPTH ≤ 2^AW
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents preserved, ready immediately

- clk  in  1  clock; all state updates on rising edge. Integration drives it with the core's inverted clock, as for the macro.
- rst  in  1  synchronous, active-high reset
- CEN  in  1  chip enable, active low
- WEN  in  1  write enable, active low; sampled only when CEN=0
- A  in  AW  word address
- D  in  DW  write data
- OEN  in  1  output enable, active low; combinational gate on Q
- Q  out  DW  read data
- busy  out  1  high while the clear sequence runs
- addr_err  out  1  one-cycle pulse on an access with A ≥ DEPTH

## Operation
- FSM states:
  - CLEAR: walks clr_ptr 0..DEPTH-1 and writes 0 to mem[clr_ptr], one word per cycle.
  - READY: serves accesses.
- State transitions:
  - rst=1 → CLEAR if CLEAR_ON_RESET=1, else READY.
  - CLEAR → READY on the edge that writes word DEPTH-1.
- Reset values: state as above, clr_ptr=0, q_reg=0, addr_err=0, busy = (CLEAR_ON_RESET==1).
- Reset does not touch mem when CLEAR_ON_RESET=0.
- READY, CEN=0, WEN=1, A<DEPTH (read): q_reg ← mem[A].
- READY, CEN=0, WEN=0, A<DEPTH (write): mem[A] ← D; q_reg holds its value. No write-through.
- READY, CEN=1: no state change; q_reg holds.
- A ≥ DEPTH with CEN=0:
  - A write is dropped.
  - A read loads q_reg ← 0.
  - addr_err=1 for that cycle only.
- During CLEAR, all requests are ignored: no write, q_reg holds, addr_err stays 0.
- Output: Q = (OEN==0) ? q_reg : 0. Zero is driven rather than Z, so no tri-state logic appears in the netlist.
- Read-after-write to the same address on consecutive edges returns the new data.
- A read and a write never occur on the same edge; WEN selects exactly one.

## Timing
- Read latency: 1 edge. Request is sampled on edge N; Q is valid after edge N (combinational through OEN). The single-cycle core therefore sees data within the same core cycle, because the memory edge falls mid-cycle.
- Write takes effect on the sampling edge and is visible to a read sampled on the next edge.
- Clear duration is exactly DEPTH cycles: busy is high for edges 1..DEPTH after reset release and falls after the last clear write.
- rst asserted during CLEAR restarts the sequence at clr_ptr=0 with a full DEPTH-cycle duration.
- rst asserted in READY aborts any request on that edge: no write occurs and q_reg ← 0.
- clr_ptr width is AW+1 so that DEPTH=2^AW terminates without wrap-around.
- OEN affects Q combinationally only; it never changes state.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=128 → busy high for exactly 128 cycles; then reads of words 0, 64 and 127 return 0; Q=0 throughout reset.
- Preload mem[0]=15 and mem[1]=20 with CLEAR_ON_RESET=0; read A=0 then A=1 → Q=15 then Q=20, each one edge after its request; busy never asserts.
- Write D=30 to A=4, then read A=4 on the next edge → Q=30; q_reg unchanged on the write edge, e.g. it still holds 20 from the prior read.
- Read A=1 with OEN=1 → Q=0; deassert OEN with no new request → Q=20 without any clock edge.
- DEPTH=100: write D=0xDEADBEEF to A=100 → addr_err pulses for 1 cycle and mem is unchanged; read A=100 → Q=0 with addr_err pulsed; read A=99 → stored value and addr_err=0.
- Assert rst at clear cycle 50 → busy remains high for 128 further cycles. Write to A=5 during CLEAR → ignored, and a read of A=5 after CLEAR returns 0.
